counter_seq_ctrl: RTL and testbench

//  Sequencer/controller for the board's up/down step counter. Replaces the free-running divided clock with a

---
 rtl/counter_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Sequencer/controller for the up/down step counter. A prescaler
//            produces one count step every DIV system-clock cycles. Provides a
//            config handshake, go/hold/abort control and terminal detection.
// Options  : COUNTER_SEQ_EVT_CNT_EN - adds the 8-bit saturating evt_cnt output
//            counting terminal events (reload or entry to DONE).
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_reload,
  input  logic             go,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
`ifdef COUNTER_SEQ_EVT_CNT_EN
  ,
  output logic [7:0]       evt_cnt
`endif
);

  // Prescaler width is derived from DIV; a floor of 1 keeps the vector legal.
  localparam int            PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_MAX = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_limit;
  logic             r_down;
  logic             r_reload;
  logic [PW-1:0]    r_presc;
  logic             r_tick;

  logic w_cfg_state;   // states in which config and go are honoured
  logic w_accept;      // config handshake completes on this edge
  logic w_launch;      // go honoured on this edge
  logic w_active;      // prescaler advances on this edge
  logic w_wrap;        // prescaler is at its last value
  logic w_step;        // a count step happens on this edge
  logic w_at_limit;    // counter sits on the terminal value
  logic w_terminal;    // the step on this edge is a terminal event

  assign w_cfg_state = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = cfg_valid && w_cfg_state;
  assign w_launch    = go && w_cfg_state;
  // Hold freezes the prescaler on any edge it is sampled high, so a step
  // always lands after exactly DIV hold-low edges in RUN/PAUSE.
  assign w_active    = ((r_state == S_RUN) || (r_state == S_PAUSE)) && !hold;
  assign w_wrap      = (r_presc == C_PRESC_MAX);
  assign w_step      = w_active && w_wrap;
  assign w_at_limit  = (r_count == r_limit);
  assign w_terminal  = w_step && w_at_limit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: abort beats hold, hold beats step
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (go) w_state_nxt = S_RUN;
        end
        S_RUN, S_PAUSE: begin
          if (w_terminal && !r_reload) begin
            w_state_nxt = S_DONE;
          end else if (hold) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register only
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:  cfg_ready = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_PAUSE: busy      = 1'b1;
      S_DONE: begin
        cfg_ready = 1'b1;
        done      = 1'b1;
      end
      default: cfg_ready = 1'b0;
    endcase
  end

  // Datapath: config latch, prescaler, counter and tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_start  <= '0;
      r_limit  <= '0;
      r_down   <= 1'b0;
      r_reload <= 1'b0;
      r_presc  <= '0;
      r_tick   <= 1'b0;
    end else if (abort) begin
      // Configuration is kept so a later go restarts the same sequence.
      r_count <= r_start;
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_step;
      if (w_accept) begin
        r_start  <= cfg_start;
        r_limit  <= cfg_limit;
        r_down   <= cfg_down;
        r_reload <= cfg_reload;
        r_count  <= cfg_start;
      end
      if (w_launch) begin
        // A config accepted on the same edge supplies the start value.
        r_presc <= '0;
        r_count <= w_accept ? cfg_start : r_start;
      end
      if (w_active) begin
        if (w_wrap) begin
          r_presc <= '0;
          if (w_at_limit) begin
            if (r_reload) r_count <= r_start;
          end else if (r_down) begin
            r_count <= r_count - WIDTH'(1);
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

`ifdef COUNTER_SEQ_EVT_CNT_EN
  logic [7:0] r_evt_cnt;

  // Saturating terminal-event counter, cleared by abort and config accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_cnt <= 8'd0;
    end else if (abort || w_accept) begin
      r_evt_cnt <= 8'd0;
    end else if (w_terminal && (r_evt_cnt != 8'hFF)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`endif

  assign count = r_count;
  assign tick  = r_tick;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Brief    : Directed self-checking bench for counter_seq_ctrl (WIDTH=4, DIV=4).
//            Define COUNTER_SEQ_EVT_CNT_EN to also exercise evt_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_start;
  logic [3:0] cfg_limit;
  logic       cfg_down;
  logic       cfg_reload;
  logic       go;
  logic       hold;
  logic       abort;
  logic [3:0] count;
  logic       tick;
  logic       busy;
  logic       done;
  logic [1:0] state;
`ifdef COUNTER_SEQ_EVT_CNT_EN
  logic [7:0] evt_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  counter_seq_ctrl #(.WIDTH(4), .DIV(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_limit  (cfg_limit),
    .cfg_down   (cfg_down),
    .cfg_reload (cfg_reload),
    .go         (go),
    .hold       (hold),
    .abort      (abort),
    .count      (count),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .state      (state)
`ifdef COUNTER_SEQ_EVT_CNT_EN
    ,
    .evt_cnt    (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n clock edges, leaving time 1 unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [3:0] s, input logic [3:0] l, input logic d, input logic r);
    cfg_start  = s;
    cfg_limit  = l;
    cfg_down   = d;
    cfg_reload = r;
  endtask

  logic [3:0] t3_exp [5];
  logic [3:0] t7_exp [3];

  initial begin
    t3_exp = '{4'd0, 4'd15, 4'd14, 4'd1, 4'd0};
    t7_exp = '{4'd15, 4'd0, 4'd1};
    rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; hold = 1'b0; abort = 1'b0;
    set_cfg(4'd0, 4'd0, 1'b0, 1'b0);

    // 1: reset state
    cyc(2);
    chk("rst_count", count, 0);
    chk("rst_state", state, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    cyc(1);

    // 2: up one-shot 3..6, accept and go on the same edge
    set_cfg(4'd3, 4'd6, 1'b0, 1'b0);
    cfg_valid = 1'b1; go = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; go = 1'b0;
    chk("t2_load_count", count, 3);
    chk("t2_run_state", state, 1);
    chk("t2_busy", busy, 1);
    chk("t2_cfg_ready_run", cfg_ready, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      chk("t2_no_tick", tick, 0);
      cyc(1);
      chk("t2_tick", tick, 1);
      chk("t2_count", count, 3 + k);
    end
    cyc(4);
    chk("t2_term_tick", tick, 1);
    chk("t2_done_state", state, 3);
    chk("t2_done", done, 1);
    chk("t2_busy_done", busy, 0);
    chk("t2_term_count", count, 6);
    cyc(1);
    chk("t2_tick_clear", tick, 0);
    chk("t2_count_hold", count, 6);
    chk("t2_cfg_ready_done", cfg_ready, 1);

    // 3: down auto-reload 1 -> 14 from DONE, wrapping 0 -> 15
    set_cfg(4'd1, 4'd14, 1'b1, 1'b1);
    cfg_valid = 1'b1; go = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; go = 1'b0;
    chk("t3_load_count", count, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(4);
      chk("t3_count", count, t3_exp[k]);
      chk("t3_tick", tick, 1);
      chk("t3_state", state, 1);
    end

    // 4: hold while prescaler=2, ten cycles, then release
    cyc(2);
    chk("t4_pre_tick", tick, 0);
    hold = 1'b1;
    cyc(1);
    chk("t4_pause_state", state, 2);
    cyc(9);
    chk("t4_pause_hold", state, 2);
    chk("t4_frozen_count", count, 0);
    chk("t4_pause_tick", tick, 0);
    hold = 1'b0;
    cyc(1);
    chk("t4_resume_state", state, 1);
    chk("t4_resume_no_tick", tick, 0);
    cyc(1);
    chk("t4_step_tick", tick, 1);
    chk("t4_step_count", count, 15);

    // 5: abort+hold on a wrap edge, then config attempt while running
    cyc(3);
    abort = 1'b1; hold = 1'b1;
    cyc(1);
    abort = 1'b0; hold = 1'b0;
    chk("t5_abort_state", state, 0);
    chk("t5_abort_count", count, 1);
    chk("t5_abort_tick", tick, 0);
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    chk("t5_rerun_state", state, 1);
    set_cfg(4'd9, 4'd9, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    chk("t5_cfg_ready_run", cfg_ready, 0);
    cyc(1);
    cfg_valid = 1'b0;
    chk("t5_cfg_ignored", count, 1);
    cyc(2);
    chk("t5_no_tick", tick, 0);
    cyc(1);
    chk("t5_step_tick", tick, 1);
    chk("t5_old_cfg_step", count, 0);

    // 7: up one-shot 14 -> 1 wrapping 15 -> 0
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    set_cfg(4'd14, 4'd1, 1'b0, 1'b0);
    cfg_valid = 1'b1; go = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      chk("t7_count", count, t7_exp[k]);
    end
    cyc(4);
    chk("t7_done_state", state, 3);
    chk("t7_done_count", count, 1);

    // 8: start == limit one-shot terminates on the first step
    set_cfg(4'd7, 4'd7, 1'b0, 1'b0);
    cfg_valid = 1'b1; go = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; go = 1'b0;
    cyc(3);
    chk("t8_still_run", state, 1);
    cyc(1);
    chk("t8_done_state", state, 3);
    chk("t8_tick", tick, 1);
    chk("t8_count", count, 7);

`ifdef COUNTER_SEQ_EVT_CNT_EN
    // 6: terminal-event counter saturation and clear
    set_cfg(4'd5, 4'd5, 1'b0, 1'b1);
    cfg_valid = 1'b1; go = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; go = 1'b0;
    chk("t6_evt_clear", evt_cnt, 0);
    cyc(16);
    chk("t6_evt_4", evt_cnt, 4);
    cyc(4 * 296);
    chk("t6_evt_sat", evt_cnt, 255);
    chk("t6_count", count, 5);
    chk("t6_state", state, 1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t6_evt_abort", evt_cnt, 0);
    chk("t6_abort_state", state, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
